lif_neuron_cluster: RTL



---
 rtl/lif_neuron_cluster.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/lif_neuron_cluster.sv
// lif_neuron_cluster
//
// A cluster of NUM_NEURONS leaky integrate-and-fire neurons. They share one
// datapath that performs decay, accumulate and threshold, and they are
// processed one neuron per clock.
//
// Between time steps the block is in ACCUM. In that state weighted input
// events are added into a per-neuron accumulator. A time_step pulse starts a
// SWEEP, which visits every neuron exactly once. The spike vector that the
// sweep collects is then presented with a one-cycle spike_valid.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous reset, active low
//   time_step    single-cycle pulse that starts a sweep
//   cfg_we       configuration write strobe (honoured only in ACCUM)
//   cfg_addr     0 threshold, 1 decay shift, 2 reset potential,
//                3 refractory period, 4 reset mode
//   cfg_data     configuration write data
//   in_valid     input event valid
//   in_ready     input event accepted when high together with in_valid
//   in_neuron    target neuron of the input event
//   in_weight    signed weight of the input event
//   spikes       spike vector of the last completed sweep
//   spike_valid  one-cycle pulse, high when spikes has just been updated
//   busy         high while a sweep is running
//   overrun      sticky flag, set by a time_step that arrives while busy
module lif_neuron_cluster #(
    parameter int                      NUM_NEURONS = 16,
    parameter int                      ID_W        = 4,
    parameter int                      POT_W       = 32,
    parameter int                      REF_W       = 4,
    parameter logic signed [POT_W-1:0] THRESH_INIT = 32'sd1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   time_step,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [POT_W-1:0]       cfg_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ID_W-1:0]        in_neuron,
    input  logic [POT_W-1:0]       in_weight,
    output logic [NUM_NEURONS-1:0] spikes,
    output logic                   spike_valid,
    output logic                   busy,
    output logic                   overrun
);

    typedef enum logic {ACCUM, SWEEP} state_t;

    localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
    localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

    // The argument is one bit wider than the result. When its top two bits
    // differ, the value has left the POT_W range and is clamped.
    function automatic logic signed [POT_W-1:0] sat(input logic signed [POT_W:0] x);
        if (x[POT_W] != x[POT_W-1])
            return x[POT_W] ? POT_MIN : POT_MAX;
        return x[POT_W-1:0];
    endfunction

    state_t                   state_q;
    logic [ID_W-1:0]          idx_q;
    logic [NUM_NEURONS-1:0]   spk_acc_q;
    logic [NUM_NEURONS-1:0]   spikes_q;
    logic                     spike_valid_q;
    logic                     overrun_q;

    logic signed [POT_W-1:0]  thresh_q;
    logic [4:0]               shift_q;
    logic signed [POT_W-1:0]  v_reset_q;
    logic [REF_W-1:0]         refr_q;
    logic                     mode_q;

    // Per-neuron state, gathered into arrays so the shared datapath can read it
    logic signed [POT_W-1:0]  v_arr   [NUM_NEURONS];
    logic signed [POT_W-1:0]  acc_arr [NUM_NEURONS];
    logic [REF_W-1:0]         r_arr   [NUM_NEURONS];

    logic                     last_idx;
    logic                     in_range;
    logic                     acc_we;
    logic signed [POT_W-1:0]  acc_sum;

    logic signed [POT_W-1:0]  v_cur;
    logic signed [POT_W-1:0]  acc_cur;
    logic [REF_W-1:0]         r_cur;
    logic signed [POT_W-1:0]  leak;
    logic signed [POT_W-1:0]  decayed;
    logic signed [POT_W-1:0]  s_sum;
    logic                     fire;
    logic signed [POT_W-1:0]  v_new;
    logic [REF_W-1:0]         r_new;
    logic [NUM_NEURONS-1:0]   fire_vec;
    logic [NUM_NEURONS-1:0]   spk_next;

    assign in_ready    = (state_q == ACCUM);
    assign busy        = (state_q == SWEEP);
    assign spikes      = spikes_q;
    assign spike_valid = spike_valid_q;
    assign overrun     = overrun_q;

    assign last_idx = (idx_q == ID_W'(NUM_NEURONS - 1));
    assign in_range = (int'(in_neuron) < NUM_NEURONS);
    assign acc_we   = in_valid && (state_q == ACCUM) && in_range;
    assign acc_sum  = sat({acc_arr[in_neuron][POT_W-1], acc_arr[in_neuron]} +
                          {in_weight[POT_W-1], in_weight});

    // Shared sweep datapath for neuron idx_q
    assign v_cur   = v_arr[idx_q];
    assign acc_cur = acc_arr[idx_q];
    assign r_cur   = r_arr[idx_q];

    always_comb begin
        leak = '0;
        if (int'(shift_q) >= POT_W)
            leak = {POT_W{v_cur[POT_W-1]}};
        else
            leak = v_cur >>> shift_q;
        // A shift of zero means no leak. It cannot go through the
        // subtraction, because v - (v >>> 0) would give zero.
        decayed = (shift_q == 5'd0) ? v_cur : v_cur - leak;
        s_sum   = sat({decayed[POT_W-1], decayed} + {acc_cur[POT_W-1], acc_cur});
        fire    = (r_cur == '0) && (s_sum >= thresh_q);
        v_new   = s_sum;
        r_new   = '0;
        if (r_cur != '0) begin
            v_new = v_cur;
            r_new = r_cur - 1'b1;
        end else if (fire) begin
            v_new = mode_q ? sat({s_sum[POT_W-1], s_sum} - {thresh_q[POT_W-1], thresh_q})
                           : v_reset_q;
            r_new = refr_q;
        end
    end

    // One register set per neuron
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
        logic signed [POT_W-1:0] v_q;
        logic signed [POT_W-1:0] acc_q;
        logic [REF_W-1:0]        r_q;
        logic                    sel;

        assign sel          = (state_q == SWEEP) && (idx_q == ID_W'(gi));
        assign fire_vec[gi] = sel && fire;
        assign v_arr[gi]    = v_q;
        assign acc_arr[gi]  = acc_q;
        assign r_arr[gi]    = r_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q   <= '0;
                acc_q <= '0;
                r_q   <= '0;
            end else if (sel) begin
                v_q   <= v_new;
                r_q   <= r_new;
                acc_q <= '0;
            end else if (acc_we && (in_neuron == ID_W'(gi))) begin
                acc_q <= acc_sum;
            end
        end
    end

    // The collected vector restarts at neuron 0 of every sweep
    assign spk_next = ((idx_q == '0) ? '0 : spk_acc_q) | fire_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thresh_q  <= THRESH_INIT;
            shift_q   <= '0;
            v_reset_q <= '0;
            refr_q    <= '0;
            mode_q    <= 1'b0;
        end else if (cfg_we && (state_q == ACCUM)) begin
            case (cfg_addr)
                3'd0:    thresh_q  <= cfg_data;
                3'd1:    shift_q   <= cfg_data[4:0];
                3'd2:    v_reset_q <= cfg_data;
                3'd3:    refr_q    <= cfg_data[REF_W-1:0];
                3'd4:    mode_q    <= cfg_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ACCUM;
            idx_q         <= '0;
            spk_acc_q     <= '0;
            spikes_q      <= '0;
            spike_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            spike_valid_q <= 1'b0;
            case (state_q)
                ACCUM: begin
                    if (time_step) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                    end
                end
                SWEEP: begin
                    if (time_step)
                        overrun_q <= 1'b1;
                    spk_acc_q <= spk_next;
                    if (last_idx) begin
                        state_q       <= ACCUM;
                        spikes_q      <= spk_next;
                        spike_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule
